// File: rtl/fifo_rd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_ctrl_pkg: shared async-FIFO pointer helpers and widths        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fifo_rd_ctrl_pkg;

    localparam int MAX_PTR_W = 32;

    // Pointers carry one extra wrap bit above the memory address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Zero-extended inputs decode identically, so one wide version serves every width.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_ctrl_if: read-side request, pointer and status bundle         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fifo_rd_ctrl_if
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
);
    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic                  i_r_inc;
    logic [PTR_W-1:0]      rq2_wptr;
    logic [PTR_W-1:0]      i_ae_thresh;
    logic                  i_clr_uf;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [PTR_W-1:0]      o_rptr;
    logic                  o_r_empty;
    logic                  o_r_almost_empty;
    logic [PTR_W-1:0]      o_r_count;
    logic                  o_underflow;

    modport master (
        output i_r_inc, rq2_wptr, i_ae_thresh, i_clr_uf,
        input  o_rd_en, o_rd_addr, o_rptr, o_r_empty, o_r_almost_empty,
               o_r_count, o_underflow
    );

    modport slave (
        input  i_r_inc, rq2_wptr, i_ae_thresh, i_clr_uf,
        output o_rd_en, o_rd_addr, o_rptr, o_r_empty, o_r_almost_empty,
               o_r_count, o_underflow
    );

endinterface
`default_nettype wire

// File: rtl/fifo_rd_ctrl_gray2bin_conv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray2bin_conv: combinational Gray-to-binary decode of WIDTH bits      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module gray2bin_conv
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  wire logic [WIDTH-1:0] gray,
    output logic      [WIDTH-1:0] bin
);

    always_comb begin
        bin = WIDTH'(gray2bin(MAX_PTR_W'(gray)));
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_ctrl: async-FIFO read pointers, empty/count/almost-empty and  |
// | sticky underflow, all in the read clock domain. Revision: 1.0         |
// +----------------------------------------------------------------------+
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic     i_r_clk,
    input  wire logic     i_rst_n,
    fifo_rd_ctrl_if.slave bus
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_param_check
        $error("fifo_rd_ctrl: DATA_WIDTH and ADDR_WIDTH must be positive");
    end

    logic             accept;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_nxt;
    logic [PTR_W-1:0] rgray_nxt;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] count_nxt;

    gray2bin_conv #(
        .WIDTH (PTR_W)
    ) u_wptr_dec (
        .gray (bus.rq2_wptr),
        .bin  (wbin)
    );

    always_comb begin
        accept    = bus.i_r_inc & ~bus.o_r_empty;
        rbin_nxt  = rbin + {{(PTR_W-1){1'b0}}, accept};
        rgray_nxt = PTR_W'(bin2gray(MAX_PTR_W'(rbin_nxt)));
        // Wraps modulo 2^PTR_W; legal pointer pairs never exceed the depth.
        count_nxt = wbin - rbin_nxt;
    end

    assign bus.o_rd_en   = accept;
    assign bus.o_rd_addr = rbin[ADDR_WIDTH-1:0];

    // Flags are computed from the post-increment pointer so they never lag an accept.
    always_ff @(posedge i_r_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rbin                 <= '0;
            bus.o_rptr           <= '0;
            bus.o_r_empty        <= 1'b1;
            bus.o_r_almost_empty <= 1'b1;
            bus.o_r_count        <= '0;
            bus.o_underflow      <= 1'b0;
        end else begin
            rbin                 <= rbin_nxt;
            bus.o_rptr           <= rgray_nxt;
            bus.o_r_empty        <= (rgray_nxt == bus.rq2_wptr);
            bus.o_r_almost_empty <= (count_nxt <= bus.i_ae_thresh);
            bus.o_r_count        <= count_nxt;
            if (bus.i_r_inc && bus.o_r_empty) begin
                bus.o_underflow <= 1'b1;
            end else if (bus.i_clr_uf) begin
                bus.o_underflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_rd_ctrl: directed self-checking bench, ADDR_WIDTH = 3         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fifo_rd_ctrl;

    localparam int ADDR_WIDTH = 3;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    fifo_rd_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    fifo_rd_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .i_r_clk (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] g4(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         rb;
    int         wb;
    logic [3:0] prev;
    logic       saw_wrap;

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        saw_wrap        = 1'b0;
        rst_n           = 1'b0;
        bus.i_r_inc     = 1'b0;
        bus.rq2_wptr    = '0;
        bus.i_ae_thresh = 4'd2;
        bus.i_clr_uf    = 1'b0;
        step();
        step();
        check("rst_empty", bus.o_r_empty, 1);
        check("rst_count", bus.o_r_count, 0);
        check("rst_rptr", bus.o_rptr, 0);
        check("rst_uf", bus.o_underflow, 0);
        check("rst_ae", bus.o_r_almost_empty, 1);
        rst_n = 1'b1;
        step();
        check("idle_empty", bus.o_r_empty, 1);

        // Fill to five words
        for (int k = 1; k <= 5; k++) begin
            bus.rq2_wptr = g4(k);
            step();
            check("fill_count", bus.o_r_count, k);
            check("fill_ae", bus.o_r_almost_empty, (k <= 2) ? 1 : 0);
        end
        check("fill_wptr_gray5", bus.rq2_wptr, 4'b0111);
        check("fill_empty", bus.o_r_empty, 0);

        // Drain five words
        bus.i_r_inc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("drain_rd_en", bus.o_rd_en, 1);
            check("drain_addr", bus.o_rd_addr, k);
            step();
            check("drain_count", bus.o_r_count, 4 - k);
            check("drain_ae", bus.o_r_almost_empty, ((4 - k) <= 2) ? 1 : 0);
            check("drain_empty", bus.o_r_empty, (k == 4) ? 1 : 0);
            check("drain_rptr", bus.o_rptr, g4(k + 1));
        end

        // Underflow: read while empty is ignored and sticky-flagged
        #1;
        check("uf_rd_en", bus.o_rd_en, 0);
        step();
        check("uf_rptr_hold", bus.o_rptr, 4'b0111);
        check("uf_set", bus.o_underflow, 1);
        bus.i_r_inc = 1'b0;
        step();
        check("uf_hold", bus.o_underflow, 1);
        bus.i_r_inc  = 1'b1;
        bus.i_clr_uf = 1'b1;
        step();
        check("uf_set_wins", bus.o_underflow, 1);
        bus.i_r_inc = 1'b0;
        step();
        check("uf_clear", bus.o_underflow, 0);
        bus.i_clr_uf = 1'b0;

        // Simultaneous read and write at count 1
        bus.rq2_wptr = g4(6);
        step();
        check("sim_pre_count", bus.o_r_count, 1);
        bus.rq2_wptr = g4(7);
        bus.i_r_inc  = 1'b1;
        step();
        check("sim_count", bus.o_r_count, 1);
        check("sim_empty", bus.o_r_empty, 0);
        check("sim_rptr", bus.o_rptr, g4(6));

        // Interleaved wrap-around: rb 6 -> 26 crosses 15 -> 0
        rb = 6;
        wb = 7;
        for (int i = 0; i < 20; i++) begin
            prev         = bus.o_rptr;
            wb           = (wb + 1) % 16;
            bus.rq2_wptr = g4(wb);
            #1;
            check("wrap_addr", bus.o_rd_addr, rb % 8);
            step();
            rb = (rb + 1) % 16;
            check("wrap_rptr", bus.o_rptr, g4(rb));
            check("wrap_1bit", $countones(bus.o_rptr ^ prev), 1);
            check("wrap_count", bus.o_r_count, (wb - rb + 16) % 16);
            check("wrap_le_depth", (bus.o_r_count <= 4'd8) ? 1 : 0, 1);
            if (prev == 4'b1000 && bus.o_rptr == 4'b0000) saw_wrap = 1'b1;
        end
        check("wrap_seen", saw_wrap, 1);

        // Drain the last word, underflow, then reset mid-stream
        step();
        check("last_empty", bus.o_r_empty, 1);
        step();
        check("last_uf", bus.o_underflow, 1);
        check("last_rptr", bus.o_rptr, g4(11));
        bus.rq2_wptr = '0;
        rst_n        = 1'b0;
        #1;
        check("mrst_empty", bus.o_r_empty, 1);
        check("mrst_count", bus.o_r_count, 0);
        check("mrst_rptr", bus.o_rptr, 0);
        check("mrst_uf", bus.o_underflow, 0);
        bus.i_r_inc = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_empty", bus.o_r_empty, 1);

        // Full: eight words with rbin at 0
        bus.rq2_wptr = 4'b1100;
        step();
        check("full_count", bus.o_r_count, 8);
        check("full_empty", bus.o_r_empty, 0);
        check("full_ae", bus.o_r_almost_empty, 0);
        bus.i_ae_thresh = 4'd8;
        step();
        check("ae_thresh_depth", bus.o_r_almost_empty, 1);
        bus.i_ae_thresh = 4'd7;
        step();
        check("ae_thresh_7", bus.o_r_almost_empty, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
